// File: rtl/stopwatch_pkg.sv
// Shared types, BCD limits and BCD helper functions for the stopwatch.
`timescale 1ns/1ps
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    LAP  = 2'd3
  } sw_state_t;

  localparam int CS_MAX  = 99;
  localparam int SEC_MAX = 59;

  // Convert 0..99 into two packed BCD digits, tens in [7:4].
  function automatic logic [7:0] to_bcd8(input int v);
    logic [7:0] r;
    r[7:4] = 4'((v / 10) % 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // Increment a two-digit BCD value, returning to 00 after 'last'.
  function automatic logic [7:0] bcd_inc8(input logic [7:0] v, input logic [7:0] last);
    logic [7:0] r;
    if (v == last) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  localparam logic [7:0] CS_LAST  = to_bcd8(CS_MAX);
  localparam logic [7:0] SEC_LAST = to_bcd8(SEC_MAX);

endpackage

// File: rtl/bcd_time_counter.sv
// Cascaded BCD centisecond/second/minute counter with wrap at WRAP_MIN minutes.
`timescale 1ns/1ps
module bcd_time_counter
  import stopwatch_pkg::*;
#(
  parameter int WRAP_MIN = 60
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en,
  input  logic       clear,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic [7:0] cs
);

  // Last legal minute value in BCD; reaching it at :59.99 wraps the whole time to zero.
  localparam logic [7:0] MIN_LAST = to_bcd8(WRAP_MIN - 1);

  logic [7:0] cs_reg,  cs_next;
  logic [7:0] sec_reg, sec_next;
  logic [7:0] min_reg, min_next;

  // Next-count logic: clear wins, otherwise ripple carries cs -> sec -> min.
  always_comb begin
    cs_next  = cs_reg;
    sec_next = sec_reg;
    min_next = min_reg;
    if (clear) begin
      cs_next  = 8'h00;
      sec_next = 8'h00;
      min_next = 8'h00;
    end else if (en) begin
      cs_next = bcd_inc8(cs_reg, CS_LAST);
      if (cs_reg == CS_LAST) begin
        sec_next = bcd_inc8(sec_reg, SEC_LAST);
        if (sec_reg == SEC_LAST) begin
          min_next = bcd_inc8(min_reg, MIN_LAST);
        end
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cs_reg  <= 8'h00;
      sec_reg <= 8'h00;
      min_reg <= 8'h00;
    end else begin
      cs_reg  <= cs_next;
      sec_reg <= sec_next;
      min_reg <= min_next;
    end
  end

  assign cs  = cs_reg;
  assign sec = sec_reg;
  assign min = min_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: run/stop/lap FSM, lap freeze register and display select.
`timescale 1ns/1ps
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int WRAP_MIN = 60
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_stop,
  input  logic       lap_reset,
  input  logic       tick,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_cs,
  output logic       running,
  output logic       lap_active
);

  sw_state_t  state_reg, state_next;
  logic       running_reg, lap_active_reg;

  logic       count_en, count_clear, lap_capture;
  logic [7:0] live_min, live_sec, live_cs;
  logic [7:0] lap_min_reg, lap_sec_reg, lap_cs_reg;

  // Next-state decode; start_stop takes priority when both buttons fire together.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start_stop) state_next = RUN;
      RUN: begin
        if (start_stop)     state_next = STOP;
        else if (lap_reset) state_next = LAP;
      end
      LAP: begin
        if (start_stop)     state_next = STOP;
        else if (lap_reset) state_next = RUN;
      end
      STOP: begin
        if (start_stop)     state_next = RUN;
        else if (lap_reset) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter control from the registered state, so a transition on the same edge keeps its tick.
  always_comb begin
    count_en    = tick && ((state_reg == RUN) || (state_reg == LAP));
    count_clear = (state_reg == STOP) && lap_reset && !start_stop;
    lap_capture = (state_reg == RUN)  && lap_reset && !start_stop;
  end

  // FSM state and its registered status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg      <= IDLE;
      running_reg    <= 1'b0;
      lap_active_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      running_reg    <= (state_next == RUN) || (state_next == LAP);
      lap_active_reg <= (state_next == LAP);
    end
  end

  // Lap register grabs the pre-increment live time on entry to LAP.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lap_min_reg <= 8'h00;
      lap_sec_reg <= 8'h00;
      lap_cs_reg  <= 8'h00;
    end else if (lap_capture) begin
      lap_min_reg <= live_min;
      lap_sec_reg <= live_sec;
      lap_cs_reg  <= live_cs;
    end
  end

  bcd_time_counter #(
    .WRAP_MIN (WRAP_MIN)
  ) u_counter (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (count_en),
    .clear (count_clear),
    .min   (live_min),
    .sec   (live_sec),
    .cs    (live_cs)
  );

  // Display shows the frozen lap time while in LAP, otherwise the live count.
  always_comb begin
    if (state_reg == LAP) begin
      disp_min = lap_min_reg;
      disp_sec = lap_sec_reg;
      disp_cs  = lap_cs_reg;
    end else begin
      disp_min = live_min;
      disp_sec = live_sec;
      disp_cs  = live_cs;
    end
  end

  assign running    = running_reg;
  assign lap_active = lap_active_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a centisecond-count model predicts every cycle.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;
  localparam int M_LAP  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst;
  logic ss_a, lr_a, tk_a, ss_b, lr_b, tk_b;
  logic [7:0] min_a, sec_a, cs_a, min_b, sec_b, cs_b;
  logic run_a, lap_a, run_b, lap_b;

  stopwatch_ctrl #(.WRAP_MIN(60)) dut_a (
    .clk(clk), .n_rst(n_rst), .start_stop(ss_a), .lap_reset(lr_a), .tick(tk_a),
    .disp_min(min_a), .disp_sec(sec_a), .disp_cs(cs_a),
    .running(run_a), .lap_active(lap_a)
  );

  stopwatch_ctrl #(.WRAP_MIN(2)) dut_b (
    .clk(clk), .n_rst(n_rst), .start_stop(ss_b), .lap_reset(lr_b), .tick(tk_b),
    .disp_min(min_b), .disp_sec(sec_b), .disp_cs(cs_b),
    .running(run_b), .lap_active(lap_b)
  );

  typedef struct {
    string       tag;
    logic [25:0] exp;
    bit          sel;
  } sb_item_t;

  sb_item_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: state and elapsed centiseconds per DUT (0 = WRAP_MIN 60, 1 = WRAP_MIN 2).
  int m_st[2];
  int m_cnt[2];
  int m_lap[2];
  int wrap_cs[2] = '{360000, 12000};

  task automatic chk(input string tag, input logic [25:0] obs, input logic [25:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r = {4'(v / 10), 4'(v % 10)};
    return r;
  endfunction

  function automatic logic [25:0] expect_vec(input bit sel);
    int d;
    logic r, l;
    d = (m_st[sel] == M_LAP) ? m_lap[sel] : m_cnt[sel];
    r = (m_st[sel] == M_RUN) || (m_st[sel] == M_LAP);
    l = (m_st[sel] == M_LAP);
    return {bcd(d / 6000), bcd((d / 100) % 60), bcd(d % 100), r, l};
  endfunction

  function automatic logic [25:0] obs_vec(input bit sel);
    if (sel) return {min_b, sec_b, cs_b, run_b, lap_b};
    return {min_a, sec_a, cs_a, run_a, lap_a};
  endfunction

  task automatic model_step(input bit sel, input bit ss, input bit lr, input bit tk);
    bit en;
    en = tk && ((m_st[sel] == M_RUN) || (m_st[sel] == M_LAP));
    if (ss) begin
      if (m_st[sel] == M_IDLE || m_st[sel] == M_STOP) m_st[sel] = M_RUN;
      else m_st[sel] = M_STOP;
    end else if (lr) begin
      case (m_st[sel])
        M_RUN:  begin m_lap[sel] = m_cnt[sel]; m_st[sel] = M_LAP; end
        M_LAP:  m_st[sel] = M_RUN;
        M_STOP: begin m_cnt[sel] = 0; m_st[sel] = M_IDLE; end
        default: ;
      endcase
    end
    if (en) m_cnt[sel] = (m_cnt[sel] + 1) % wrap_cs[sel];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = M_IDLE; m_cnt[i] = 0; m_lap[i] = 0;
    end
  endtask

  task automatic zero_inputs();
    ss_a = 0; lr_a = 0; tk_a = 0; ss_b = 0; lr_b = 0; tk_b = 0;
  endtask

  // One clock: drive inputs, predict, then compare at the following negedge.
  task automatic cyc(input bit sel, input bit ss, input bit lr, input bit tk, input string tag);
    sb_item_t e;
    zero_inputs();
    if (sel) begin ss_b = ss; lr_b = lr; tk_b = tk; end
    else     begin ss_a = ss; lr_a = lr; tk_a = tk; end
    model_step(sel, ss, lr, tk);
    sb.push_back('{tag, expect_vec(sel), sel});
    @(negedge clk);
    e = sb.pop_front();
    chk(e.tag, obs_vec(e.sel), e.exp);
  endtask

  task automatic check_now(input bit sel, input string tag);
    sb_item_t e;
    sb.push_back('{tag, expect_vec(sel), sel});
    e = sb.pop_front();
    chk(e.tag, obs_vec(e.sel), e.exp);
  endtask

  initial begin
    zero_inputs();
    n_rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_now(0, "reset_a");
    check_now(1, "reset_b");
    chk("reset_zero", obs_vec(0), 26'h0);
    #2 n_rst = 1'b1;
    @(negedge clk);

    // Ticks while idle do nothing.
    repeat (250) cyc(0, 0, 0, 1, "idle_tick");
    chk("idle_250", obs_vec(0), 26'h0);

    // Run 6123 cs, stop, ticks ignored, clear.
    cyc(0, 1, 0, 0, "start");
    repeat (6123) cyc(0, 0, 0, 1, "run");
    cyc(0, 1, 0, 0, "stop");
    chk("stop_010123", obs_vec(0), {24'h010123, 2'b00});
    repeat (10) cyc(0, 0, 0, 1, "stop_tick");
    chk("stop_hold", obs_vec(0), {24'h010123, 2'b00});
    cyc(0, 0, 1, 0, "clear");
    chk("cleared", obs_vec(0), 26'h0);

    // Lap freeze at 00:05.00, 300 ticks, unfreeze shows 00:08.00.
    cyc(0, 1, 0, 0, "start2");
    repeat (500) cyc(0, 0, 0, 1, "run2");
    cyc(0, 0, 1, 0, "lap_in");
    chk("lap_frozen", obs_vec(0), {24'h000500, 2'b11});
    repeat (300) cyc(0, 0, 0, 1, "lap_tick");
    chk("lap_still", obs_vec(0), {24'h000500, 2'b11});
    cyc(0, 0, 1, 0, "lap_out");
    chk("lap_out_0800", obs_vec(0), {24'h000800, 2'b10});
    cyc(0, 1, 0, 0, "stop3");
    cyc(0, 0, 1, 0, "clear3");

    // Both buttons plus tick in RUN: stop wins and the tick still counts.
    cyc(0, 1, 0, 0, "start4");
    repeat (5) cyc(0, 0, 0, 1, "run4");
    cyc(0, 1, 1, 1, "both");
    chk("both_stop", obs_vec(0), {24'h000006, 2'b00});
    cyc(0, 0, 1, 0, "clear4");

    // Async reset mid-cycle while in LAP at 00:42.17.
    cyc(0, 1, 0, 0, "start5");
    repeat (4217) cyc(0, 0, 0, 1, "run5");
    cyc(0, 0, 1, 0, "lap5");
    repeat (3) cyc(0, 0, 0, 1, "lap5_tick");
    chk("lap_4217", obs_vec(0), {24'h004217, 2'b11});
    zero_inputs();
    #2 n_rst = 1'b0;
    model_reset();
    #1 check_now(0, "async_rst");
    @(negedge clk);
    check_now(0, "rst_held");
    #2 n_rst = 1'b1;
    @(negedge clk);
    repeat (5) cyc(0, 0, 0, 1, "post_rst_idle");

    // Minute carry and wrap on the short instance.
    cyc(1, 1, 0, 0, "b_start");
    repeat (11999) cyc(1, 0, 0, 1, "b_run");
    chk("b_015999", obs_vec(1), {24'h015999, 2'b10});
    cyc(1, 0, 0, 1, "b_wrap");
    chk("b_wrapped", obs_vec(1), {24'h000000, 2'b10});
    repeat (3) cyc(1, 0, 0, 1, "b_after_wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
